mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 22 ++
 rtl/mem_load_align.sv | 42 ++++
 rtl/mem_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: datapath widths and load-type encoding.
// Latency: n/a (constants and a helper function only).
// Backpressure: n/a.
package mem_stage_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   typedef enum logic [2:0] {
      LOAD_NONE = 3'b000,
      LD_B      = 3'b001,
      LD_H      = 3'b010,
      LD_W      = 3'b011,
      LD_BU     = 3'b100,
      LD_HU     = 3'b101
   } load_op_e;

   function automatic logic is_load(input logic [2:0] op);
      return op != LOAD_NONE;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts the byte/half/word selected by the low address bits and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none (no state).
// Ports: rdata (raw 32-bit read data), addr_lo (address bits [1:0]), load_op (load type),
//        load_data (aligned, extended result; 0 when load_op is not a load).
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  load_op,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (addr_lo)
         2'b00:   byte_sel = rdata[7:0];
         2'b01:   byte_sel = rdata[15:8];
         2'b10:   byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      // Halfword lane chosen by bit 1 only; bit 0 is ignored (no alignment check).
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      load_data = '0;
      case (load_op)
         LD_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
         LD_BU:   load_data = {24'd0, byte_sel};
         LD_H:    load_data = {{16{half_sel[15]}}, half_sel};
         LD_HU:   load_data = {16'd0, half_sel};
         LD_W:    load_data = rdata;
         default: load_data = '0;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: holds one instruction, waits for its data-SRAM response, forms the WB result.
// Latency: non-memory op offered to WB 1 cycle after capture; load/store offered in the data_ok cycle.
// Backpressure: valid/ready both sides; a response arriving while WB stalls is buffered until it drains.
// Ports: EX side ex_to_mem_* / o_mem_ready, SRAM response data_sram_data_ok/rdata,
//        WB side mem_to_wb_* / i_wb_ready, hazard view mem_active/mem_rf_waddr/mem_rf_we.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_to_mem_valid,
   output logic        o_mem_ready,
   input  logic [31:0] ex_to_mem_alu_result,
   input  logic [4:0]  ex_to_mem_rf_waddr,
   input  logic        ex_to_mem_rf_we,
   input  logic [31:0] ex_to_mem_pc,
   input  logic [31:0] ex_to_mem_inst,
   input  logic        ex_to_mem_mem_req,
   input  logic [2:0]  ex_to_mem_load_op,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata,
   output logic        mem_to_wb_valid,
   input  logic        i_wb_ready,
   output logic [31:0] mem_to_wb_rf_wdata,
   output logic [4:0]  mem_to_wb_rf_waddr,
   output logic        mem_to_wb_rf_we,
   output logic [31:0] mem_to_wb_pc,
   output logic [31:0] mem_to_wb_inst,
   output logic        mem_active,
   output logic [4:0]  mem_rf_waddr,
   output logic        mem_rf_we
);

   logic        mem_valid;
   logic        resp_pend;
   logic        resp_got;
   logic [31:0] rdata_buf;

   logic [31:0] pld_alu_result;
   logic [4:0]  pld_rf_waddr;
   logic        pld_rf_we;
   logic [31:0] pld_pc;
   logic [31:0] pld_inst;
   logic [2:0]  pld_load_op;

   logic        mem_ready_go;
   logic        capture;
   logic        leave;
   logic        rsp_take;
   logic [31:0] rdata_sel;
   logic [31:0] load_data;

   assign mem_ready_go = !resp_pend || data_sram_data_ok || resp_got;
   assign mem_to_wb_valid = mem_valid && mem_ready_go;
   assign o_mem_ready = !mem_valid || (mem_ready_go && i_wb_ready);
   assign capture = ex_to_mem_valid && o_mem_ready;
   assign leave = mem_to_wb_valid && i_wb_ready;
   // data_ok only means something while a request is outstanding; stray pulses are dropped.
   assign rsp_take = resp_pend && data_sram_data_ok;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_valid <= 1'b0;
         resp_pend <= 1'b0;
         resp_got  <= 1'b0;
         rdata_buf <= '0;
      end else begin
         if (o_mem_ready) begin
            mem_valid <= ex_to_mem_valid;
         end
         // A newly captured request wins over clearing the one that is retiring this edge.
         if (capture) begin
            resp_pend <= ex_to_mem_mem_req;
         end else if (rsp_take) begin
            resp_pend <= 1'b0;
         end
         if (leave) begin
            resp_got  <= 1'b0;
            rdata_buf <= '0;
         end else if (rsp_take && !i_wb_ready) begin
            resp_got  <= 1'b1;
            rdata_buf <= data_sram_rdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pld_alu_result <= '0;
         pld_rf_waddr   <= '0;
         pld_rf_we      <= 1'b0;
         pld_pc         <= '0;
         pld_inst       <= '0;
         pld_load_op    <= LOAD_NONE;
      end else if (capture) begin
         pld_alu_result <= ex_to_mem_alu_result;
         pld_rf_waddr   <= ex_to_mem_rf_waddr;
         pld_rf_we      <= ex_to_mem_rf_we;
         pld_pc         <= ex_to_mem_pc;
         pld_inst       <= ex_to_mem_inst;
         pld_load_op    <= ex_to_mem_load_op;
      end
   end

   // Once buffered, the live SRAM bus may change; keep presenting the captured word.
   assign rdata_sel = resp_got ? rdata_buf : data_sram_rdata;

   mem_load_align u_align (
      .rdata     (rdata_sel),
      .addr_lo   (pld_alu_result[1:0]),
      .load_op   (pld_load_op),
      .load_data (load_data)
   );

   assign mem_to_wb_rf_wdata = is_load(pld_load_op) ? load_data : pld_alu_result;
   assign mem_to_wb_rf_waddr = pld_rf_waddr;
   assign mem_to_wb_rf_we    = pld_rf_we;
   assign mem_to_wb_pc       = pld_pc;
   assign mem_to_wb_inst     = pld_inst;

   assign mem_active   = mem_valid;
   assign mem_rf_waddr = mem_valid ? pld_rf_waddr : 5'd0;
   assign mem_rf_we    = mem_valid && pld_rf_we;

endmodule
